rename_stage: RTL and testbench
===============================

RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 Parameters: MAX_OPERANDS=3 (operand slots), ARN_BITS=6, PRN_BITS=6 (64 physical registers), FU_COUNT=4, INST_ID_BITS=6.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
REQ-003 Inputs from fetch/decode:
- instr_valid  in  1  instruction present
- in_raw_instr  in  32  raw instruction
- in_instr_pc  in  64  instruction PC
- in_fu_choice  in  2  target functional unit
- arn_inputs[3]  in  6 each  source ARNs
- arn_outputs[3]  in  6 each  destination ARNs
REQ-004 Other inputs:
- new_inst_id  in  6  instruction ID supplied by the ROB
- free_valid[3], free_prns[3]  in  1/6  PRNs released at commit
- set_prn_ready_valid[4][3], set_prn_ready[4][3]  in  1/6  result-ready broadcasts, per FU and per slot
- stall  in  1  downstream cannot accept
REQ-005 Outputs:
- mapping_valid  out  1  output register holds a renamed instruction
- mapping_valid_comb  out  1  handoff strobe for this cycle
- inst_id  out  6  instruction ID
- raw_instr  out  32  raw instruction
- instr_pc  out  64  instruction PC
- fu_choice  out  2  target functional unit
- prn_input_valid[3], prn_input_ready[3], prn_input[3]  out  1/1/6  renamed sources
- prn_output_valid[3], prn_output[3]  out  1/6  allocated destinations
- mapping_inputs_valid[3], mapping_inputs_prn[3], mapping_inputs_arn[3]  out  1/6/6  superseded mappings, freed at commit
- stall_fed  out  1  upstream must hold its instruction

Function
REQ-006 ARN 0..31 are architectural; any ARN value >=32 marks an unused slot.
REQ-007 State:
- 32-entry remap table (ARN->PRN)
- 64-bit free bitmap
- 64-bit ready bitmap
- one output register
REQ-008 Handoff: handoff = mapping_valid && !stall; mapping_valid_comb SHALL equal handoff combinationally.
REQ-009 Capacity check: can_take = !mapping_valid || !stall; enough = free count >= number of valid destination slots.
REQ-010 Accept: accept = instr_valid && can_take && enough; stall_fed = !(can_take && enough).
REQ-011 Source lookup on accept: each valid source slot reads the remap table before this instruction's own updates.
- prn_input_ready = ready bit OR a matching same-cycle set_prn_ready broadcast.
- Unused source slot: prn_input_valid=0, prn_input_ready=1, prn_input=0.
REQ-012 Destination allocation on accept: each valid destination slot takes the lowest-index free PRN, in slot order 0,1,2. The allocated PRN is cleared from the free bitmap, marked not-ready, and written into the remap table.
REQ-013 Superseded mappings: mapping_inputs_prn = the prior mapping of that ARN; mapping_inputs_arn = the ARN; valid mirrors prn_output_valid.
REQ-014 Duplicate destination ARNs within one instruction: the later slot wins in the remap table. The later slot's superseded PRN is the earlier slot's newly allocated PRN.
REQ-015 Output register is loaded on accept; mapping_valid rises the next cycle (1-cycle latency). inst_id SHALL be new_inst_id passed through combinationally.
REQ-016 If handoff occurs without accept, mapping_valid clears. If stall=1 and mapping_valid=1, all outputs hold.
REQ-017 While an instruction is held, any matching set_prn_ready broadcast SHALL set its registered prn_input_ready bit (no missed wakeup).
REQ-018 free_valid slots set free bits at the clock edge. A PRN freed in a cycle is not allocatable in that same cycle.
REQ-019 set_prn_ready broadcasts set ready bits. If a PRN is allocated and broadcast ready in the same cycle, allocation wins (bit ends cleared).

Reset
REQ-020 On reset:
- remap table: ARN i -> PRN i (i=0..31)
- PRN 0..31 ready and not free; PRN 32..63 free and not-ready
- every output 0, except stall_fed, which follows REQ-010
REQ-021 Reset mid-operation discards the held instruction immediately.

Structure
REQ-022 Shared package holds MAX_OPERANDS, ARN_BITS, PRN_BITS, FU_COUNT, INST_ID_BITS.
REQ-023 One sub-module, free_list, holding the bitmap, a 3-way lowest-free priority allocator and the free-count output.

Verification
REQ-024 Reset, then instr_valid with dest ARN 1 and src ARNs 2,3 -> next cycle prn_output=32, prn_input=2,3, ready=1,1, mapping_inputs_prn=1.
REQ-025 Second instruction reads ARN 1 -> prn_input=32, ready=0. Then broadcast PRN 32 while held with stall=1 -> held prn_input_ready becomes 1.
REQ-026 Allocate all 32 free PRNs, then a further dest-writing instruction -> stall_fed=1. Free PRN 5 -> next accept allocates 5.
REQ-027 Dest ARNs 4,4 in one instruction -> PRNs 32,33; mapping_inputs_prn=4,32; a later read of ARN 4 gives 33.
REQ-028 stall=1 with mapping_valid=1 and a new instr_valid -> stall_fed=1, outputs frozen, mapping_valid_comb=0. Release stall -> mapping_valid_comb=1 for one cycle.

Source files
------------

// File: rtl/rename_stage_pkg.sv
// Shared sizes and types for the register-rename stage.
package rename_stage_pkg;
  localparam int MAX_OPERANDS = 3;
  localparam int ARN_BITS     = 6;
  localparam int PRN_BITS     = 6;
  localparam int FU_COUNT     = 4;
  localparam int INST_ID_BITS = 6;
  localparam int NUM_ARCH     = 32;
  localparam int NUM_PRN      = 1 << PRN_BITS;

  typedef logic [ARN_BITS-1:0] arn_t;
  typedef logic [PRN_BITS-1:0] prn_t;

  // ARN values at or above NUM_ARCH mark an unused operand slot.
  function automatic logic arn_used(input arn_t a);
    return a < arn_t'(NUM_ARCH);
  endfunction
endpackage

// File: rtl/rename_stage_free_list.sv
// Free-PRN bitmap with a 3-way lowest-index allocator and free count.
module free_list
  import rename_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                need[MAX_OPERANDS],
  input  logic                take,
  input  logic                free_valid[MAX_OPERANDS],
  input  prn_t                free_prns[MAX_OPERANDS],
  output prn_t                alloc_prn[MAX_OPERANDS],
  output logic [PRN_BITS:0]   free_count
);
  logic [NUM_PRN-1:0] free_bits;
  logic [NUM_PRN-1:0] avail;
  logic [NUM_PRN-1:0] freed;
  logic [NUM_PRN-1:0] free_next;
  logic               found;

  // Each slot takes the lowest PRN still available after earlier slots took theirs.
  always_comb begin
    avail = free_bits;
    found = 1'b0;
    for (int s = 0; s < MAX_OPERANDS; s++) begin
      alloc_prn[s] = '0;
      found = 1'b0;
      if (need[s]) begin
        for (int p = 0; p < NUM_PRN; p++) begin
          if (!found && avail[p]) begin
            alloc_prn[s] = PRN_BITS'(p);
            found = 1'b1;
          end
        end
        if (found) avail[alloc_prn[s]] = 1'b0;
      end
    end
  end

  always_comb begin
    freed = '0;
    for (int s = 0; s < MAX_OPERANDS; s++)
      if (free_valid[s]) freed[free_prns[s]] = 1'b1;
    free_next = (free_bits | freed) & ~(take ? (free_bits & ~avail) : '0);
  end

  assign free_count = (PRN_BITS+1)'($countones(free_bits));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) free_bits <= {{(NUM_PRN-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
    else      free_bits <= free_next;
  end
endmodule

// File: rtl/rename_stage.sv
// Register rename: maps source ARNs to PRNs, allocates destination PRNs, registers the result.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [31:0]             in_raw_instr,
  input  logic [63:0]             in_instr_pc,
  input  logic [1:0]              in_fu_choice,
  input  arn_t                    arn_inputs[MAX_OPERANDS],
  input  arn_t                    arn_outputs[MAX_OPERANDS],
  input  logic [INST_ID_BITS-1:0] new_inst_id,
  input  logic                    free_valid[MAX_OPERANDS],
  input  prn_t                    free_prns[MAX_OPERANDS],
  input  logic                    set_prn_ready_valid[FU_COUNT][MAX_OPERANDS],
  input  prn_t                    set_prn_ready[FU_COUNT][MAX_OPERANDS],
  input  logic                    stall,
  output logic                    mapping_valid,
  output logic                    mapping_valid_comb,
  output logic [INST_ID_BITS-1:0] inst_id,
  output logic [31:0]             raw_instr,
  output logic [63:0]             instr_pc,
  output logic [1:0]              fu_choice,
  output logic                    prn_input_valid[MAX_OPERANDS],
  output logic                    prn_input_ready[MAX_OPERANDS],
  output prn_t                    prn_input[MAX_OPERANDS],
  output logic                    prn_output_valid[MAX_OPERANDS],
  output prn_t                    prn_output[MAX_OPERANDS],
  output logic                    mapping_inputs_valid[MAX_OPERANDS],
  output prn_t                    mapping_inputs_prn[MAX_OPERANDS],
  output arn_t                    mapping_inputs_arn[MAX_OPERANDS],
  output logic                    stall_fed
);
  // Handshake: upstream offers instr_valid and holds it while stall_fed=1; the
  // output register hands off when mapping_valid=1 and stall=0 in the same cycle.
  prn_t               remap[NUM_ARCH];
  logic [NUM_PRN-1:0] ready_bits;
  logic [NUM_PRN-1:0] bcast_mask;
  logic [NUM_PRN-1:0] alloc_mask;
  logic               src_used[MAX_OPERANDS];
  logic               dst_used[MAX_OPERANDS];
  prn_t               src_prn[MAX_OPERANDS];
  logic               src_rdy[MAX_OPERANDS];
  prn_t               sup_prn[MAX_OPERANDS];
  prn_t               alloc_prn[MAX_OPERANDS];
  logic [PRN_BITS:0]  free_count;
  logic [PRN_BITS:0]  dst_count;
  logic               handoff, can_take, enough, accept;

  free_list u_free_list (
    .clk        (clk),
    .rst        (rst),
    .need       (dst_used),
    .take       (accept),
    .free_valid (free_valid),
    .free_prns  (free_prns),
    .alloc_prn  (alloc_prn),
    .free_count (free_count)
  );

  always_comb begin
    bcast_mask = '0;
    for (int f = 0; f < FU_COUNT; f++)
      for (int s = 0; s < MAX_OPERANDS; s++)
        if (set_prn_ready_valid[f][s]) bcast_mask[set_prn_ready[f][s]] = 1'b1;
  end

  // Sources read the table before this instruction's own writes; a later
  // duplicate destination supersedes the PRN the earlier slot just took.
  always_comb begin
    dst_count  = '0;
    alloc_mask = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      src_used[i] = arn_used(arn_inputs[i]);
      dst_used[i] = arn_used(arn_outputs[i]);
      src_prn[i]  = remap[arn_inputs[i][4:0]];
      src_rdy[i]  = ready_bits[src_prn[i]] | bcast_mask[src_prn[i]];
      sup_prn[i]  = remap[arn_outputs[i][4:0]];
      for (int j = 0; j < i; j++)
        if (dst_used[j] && arn_outputs[j] == arn_outputs[i]) sup_prn[i] = alloc_prn[j];
      if (dst_used[i]) begin
        dst_count = dst_count + 1'b1;
        alloc_mask[alloc_prn[i]] = 1'b1;
      end
    end
  end

  assign handoff            = mapping_valid && !stall;
  assign can_take           = !mapping_valid || !stall;
  assign enough             = free_count >= dst_count;
  assign accept             = instr_valid && can_take && enough;
  assign stall_fed          = !(can_take && enough);
  assign mapping_valid_comb = handoff;
  assign inst_id            = new_inst_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < NUM_ARCH; a++) remap[a] <= PRN_BITS'(a);
      ready_bits <= {{(NUM_PRN-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
    end else begin
      ready_bits <= (ready_bits | bcast_mask) & ~(accept ? alloc_mask : '0);
      if (accept)
        for (int i = 0; i < MAX_OPERANDS; i++)
          if (dst_used[i]) remap[arn_outputs[i][4:0]] <= alloc_prn[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mapping_valid <= 1'b0;
      raw_instr     <= '0;
      instr_pc      <= '0;
      fu_choice     <= '0;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        prn_input_valid[i]      <= 1'b0;
        prn_input_ready[i]      <= 1'b0;
        prn_input[i]            <= '0;
        prn_output_valid[i]     <= 1'b0;
        prn_output[i]           <= '0;
        mapping_inputs_valid[i] <= 1'b0;
        mapping_inputs_prn[i]   <= '0;
        mapping_inputs_arn[i]   <= '0;
      end
    end else if (accept) begin
      mapping_valid <= 1'b1;
      raw_instr     <= in_raw_instr;
      instr_pc      <= in_instr_pc;
      fu_choice     <= in_fu_choice;
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        prn_input_valid[i]      <= src_used[i];
        prn_input_ready[i]      <= src_used[i] ? src_rdy[i] : 1'b1;
        prn_input[i]            <= src_used[i] ? src_prn[i] : '0;
        prn_output_valid[i]     <= dst_used[i];
        prn_output[i]           <= dst_used[i] ? alloc_prn[i] : '0;
        mapping_inputs_valid[i] <= dst_used[i];
        mapping_inputs_prn[i]   <= dst_used[i] ? sup_prn[i] : '0;
        mapping_inputs_arn[i]   <= dst_used[i] ? arn_outputs[i] : '0;
      end
    end else begin
      if (handoff) mapping_valid <= 1'b0;
      // A held instruction must still see wakeups for its sources.
      for (int i = 0; i < MAX_OPERANDS; i++)
        if (prn_input_valid[i] && bcast_mask[prn_input[i]]) prn_input_ready[i] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rename_stage.sv
// Directed scoreboard bench for rename_stage.
module tb_rename_stage;
  import rename_stage_pkg::*;

  localparam int   W    = 96;
  localparam arn_t NONE = 6'd63;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] in_raw_instr;
  logic [63:0] in_instr_pc;
  logic [1:0]  in_fu_choice;
  arn_t        arn_inputs[3];
  arn_t        arn_outputs[3];
  logic [5:0]  new_inst_id;
  logic        free_valid[3];
  prn_t        free_prns[3];
  logic        set_prn_ready_valid[4][3];
  prn_t        set_prn_ready[4][3];
  logic        stall;
  logic        mapping_valid, mapping_valid_comb, stall_fed;
  logic [5:0]  inst_id;
  logic [31:0] raw_instr;
  logic [63:0] instr_pc;
  logic [1:0]  fu_choice;
  logic        prn_input_valid[3], prn_input_ready[3];
  prn_t        prn_input[3];
  logic        prn_output_valid[3];
  prn_t        prn_output[3];
  logic        mapping_inputs_valid[3];
  prn_t        mapping_inputs_prn[3];
  arn_t        mapping_inputs_arn[3];

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  rename_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .in_raw_instr(in_raw_instr),
    .in_instr_pc(in_instr_pc), .in_fu_choice(in_fu_choice), .arn_inputs(arn_inputs),
    .arn_outputs(arn_outputs), .new_inst_id(new_inst_id), .free_valid(free_valid),
    .free_prns(free_prns), .set_prn_ready_valid(set_prn_ready_valid),
    .set_prn_ready(set_prn_ready), .stall(stall), .mapping_valid(mapping_valid),
    .mapping_valid_comb(mapping_valid_comb), .inst_id(inst_id), .raw_instr(raw_instr),
    .instr_pc(instr_pc), .fu_choice(fu_choice), .prn_input_valid(prn_input_valid),
    .prn_input_ready(prn_input_ready), .prn_input(prn_input),
    .prn_output_valid(prn_output_valid), .prn_output(prn_output),
    .mapping_inputs_valid(mapping_inputs_valid), .mapping_inputs_prn(mapping_inputs_prn),
    .mapping_inputs_arn(mapping_inputs_arn), .stall_fed(stall_fed)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_word(
    input logic [2:0] ov, input prn_t o0, o1, o2,
    input logic [2:0] iv, input logic [2:0] ir, input prn_t i0, i1, i2,
    input prn_t m0, m1, m2, input arn_t a0, a1, a2,
    input logic [1:0] fu, input logic [7:0] raw);
    return {2'b00, ov, ov, o2, o1, o0, iv, ir, i2, i1, i0, m2, m1, m0, a2, a1, a0, fu, raw};
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {2'b00,
            mapping_inputs_valid[2], mapping_inputs_valid[1], mapping_inputs_valid[0],
            prn_output_valid[2], prn_output_valid[1], prn_output_valid[0],
            prn_output[2], prn_output[1], prn_output[0],
            prn_input_valid[2], prn_input_valid[1], prn_input_valid[0],
            prn_input_ready[2], prn_input_ready[1], prn_input_ready[0],
            prn_input[2], prn_input[1], prn_input[0],
            mapping_inputs_prn[2], mapping_inputs_prn[1], mapping_inputs_prn[0],
            mapping_inputs_arn[2], mapping_inputs_arn[1], mapping_inputs_arn[0],
            fu_choice, raw_instr[7:0]};
  endfunction

  // scoreboard comparisons
  task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_prn(input string tag, input prn_t obs, input prn_t expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // drivers
  task automatic idle();
    instr_valid  = 1'b0;
    in_raw_instr = '0;
    in_instr_pc  = '0;
    in_fu_choice = '0;
    new_inst_id  = '0;
    for (int i = 0; i < 3; i++) begin
      arn_inputs[i]  = NONE;
      arn_outputs[i] = NONE;
      free_valid[i]  = 1'b0;
      free_prns[i]   = '0;
      for (int f = 0; f < 4; f++) begin
        set_prn_ready_valid[f][i] = 1'b0;
        set_prn_ready[f][i]       = '0;
      end
    end
  endtask

  task automatic issue(input string tag, input arn_t s0, s1, s2, input arn_t d0, d1, d2,
                       input logic [1:0] fu, input logic [7:0] raw, input logic [W-1:0] expw);
    instr_valid    = 1'b1;
    arn_inputs[0]  = s0; arn_inputs[1]  = s1; arn_inputs[2]  = s2;
    arn_outputs[0] = d0; arn_outputs[1] = d1; arn_outputs[2] = d2;
    in_fu_choice   = fu;
    in_raw_instr   = {24'h0, raw};
    in_instr_pc    = 64'h1000 + {56'h0, raw};
    exp_q.push_back(expw);
    step();
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arn_inputs[i]  = NONE;
      arn_outputs[i] = NONE;
    end
    chk_bit({tag, "_valid"}, mapping_valid, 1'b1);
    if (mapping_valid && exp_q.size() > 0) chk_word(tag, obs_word(), exp_q.pop_front());
  endtask

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_mapping_valid", mapping_valid, 1'b0);
    chk_bit("rst_valid_comb", mapping_valid_comb, 1'b0);
    chk_bit("rst_stall_fed", stall_fed, 1'b0);
    chk_word("rst_outputs", obs_word(), '0);
    new_inst_id = 6'd42;
    #1;
    chk_prn("inst_id_pass", inst_id, 6'd42);
    rst = 1'b1;
    step();

    issue("t1_basic", 6'd2, 6'd3, NONE, 6'd1, NONE, NONE, 2'd1, 8'h11,
          exp_word(3'b001, 6'd32, 6'd0, 6'd0, 3'b011, 3'b111, 6'd2, 6'd3, 6'd0,
                   6'd1, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0, 2'd1, 8'h11));
    issue("t2_read_new", 6'd1, NONE, NONE, NONE, NONE, NONE, 2'd2, 8'h22,
          exp_word(3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 3'b110, 6'd32, 6'd0, 6'd0,
                   6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'd2, 8'h22));

    // held instruction wakes up on a broadcast of its source
    stall = 1'b1;
    #1;
    chk_bit("stall_valid_comb", mapping_valid_comb, 1'b0);
    set_prn_ready_valid[2][1] = 1'b1;
    set_prn_ready[2][1]       = 6'd32;
    step();
    set_prn_ready_valid[2][1] = 1'b0;
    chk_bit("held_wakeup", prn_input_ready[0], 1'b1);
    chk_bit("held_valid", mapping_valid, 1'b1);

    instr_valid   = 1'b1;
    arn_inputs[0] = 6'd5;
    in_raw_instr  = 32'h99;
    #1;
    chk_bit("stall_fed_held", stall_fed, 1'b1);
    step();
    chk_word("held_frozen", obs_word(),
             exp_word(3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 3'b111, 6'd32, 6'd0, 6'd0,
                      6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'd2, 8'h22));
    chk_bit("held_comb_low", mapping_valid_comb, 1'b0);
    instr_valid   = 1'b0;
    arn_inputs[0] = NONE;
    stall         = 1'b0;
    #1;
    chk_bit("release_comb", mapping_valid_comb, 1'b1);
    step();
    chk_bit("release_comb_once", mapping_valid_comb, 1'b0);
    chk_bit("release_cleared", mapping_valid, 1'b0);

    issue("t3_ready_set", 6'd1, NONE, NONE, NONE, NONE, NONE, 2'd0, 8'h33,
          exp_word(3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 3'b111, 6'd32, 6'd0, 6'd0,
                   6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'd0, 8'h33));

    // asynchronous reset mid-operation
    #2;
    rst = 1'b0;
    #1;
    chk_bit("midrst_valid", mapping_valid, 1'b0);
    chk_word("midrst_outputs", obs_word(), '0);
    #2;
    rst = 1'b1;
    step();

    // duplicate destinations; a same-cycle broadcast of a newly allocated PRN loses
    set_prn_ready_valid[0][0] = 1'b1;
    set_prn_ready[0][0]       = 6'd33;
    issue("t4_dup_dest", NONE, NONE, NONE, 6'd4, 6'd4, NONE, 2'd3, 8'h44,
          exp_word(3'b011, 6'd32, 6'd33, 6'd0, 3'b000, 3'b111, 6'd0, 6'd0, 6'd0,
                   6'd4, 6'd32, 6'd0, 6'd4, 6'd4, 6'd0, 2'd3, 8'h44));
    set_prn_ready_valid[0][0] = 1'b0;
    issue("t5_read_dup", 6'd4, 6'd5, NONE, NONE, NONE, NONE, 2'd0, 8'h55,
          exp_word(3'b000, 6'd0, 6'd0, 6'd0, 3'b011, 3'b110, 6'd33, 6'd5, 6'd0,
                   6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'd0, 8'h55));
    set_prn_ready_valid[3][2] = 1'b1;
    set_prn_ready[3][2]       = 6'd33;
    issue("t5b_bypass", 6'd4, NONE, NONE, NONE, NONE, NONE, 2'd1, 8'h5b,
          exp_word(3'b000, 6'd0, 6'd0, 6'd0, 3'b001, 3'b111, 6'd33, 6'd0, 6'd0,
                   6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 2'd1, 8'h5b));
    set_prn_ready_valid[3][2] = 1'b0;

    // drain the remaining 30 free PRNs
    for (int k = 0; k < 10; k++) begin
      prn_t s0, s1, s2;
      s0 = (k == 0) ? 6'd20 : 6'(31 + 3*k);
      s1 = (k == 0) ? 6'd21 : 6'(32 + 3*k);
      s2 = (k == 0) ? 6'd22 : 6'(33 + 3*k);
      issue("drain", NONE, NONE, NONE, 6'd20, 6'd21, 6'd22, 2'd0, 8'(k),
            exp_word(3'b111, 6'(34 + 3*k), 6'(35 + 3*k), 6'(36 + 3*k), 3'b000, 3'b111,
                     6'd0, 6'd0, 6'd0, s0, s1, s2, 6'd20, 6'd21, 6'd22, 2'd0, 8'(k)));
    end

    instr_valid    = 1'b1;
    arn_outputs[0] = 6'd7;
    #1;
    chk_bit("empty_stall_fed", stall_fed, 1'b1);
    step();
    chk_bit("empty_handoff_clears", mapping_valid, 1'b0);
    free_valid[0] = 1'b1;
    free_prns[0]  = 6'd5;
    #1;
    chk_bit("free_same_cycle", stall_fed, 1'b1);
    step();
    free_valid[0] = 1'b0;
    #1;
    chk_bit("free_next_cycle", stall_fed, 1'b0);
    issue("t6_realloc", NONE, NONE, NONE, 6'd7, NONE, NONE, 2'd1, 8'h77,
          exp_word(3'b001, 6'd5, 6'd0, 6'd0, 3'b000, 3'b111, 6'd0, 6'd0, 6'd0,
                   6'd7, 6'd0, 6'd0, 6'd7, 6'd0, 6'd0, 2'd1, 8'h77));

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
